// File: rtl/mcu_spi_slave.sv
// mcu_spi_slave
//   SPI slave (mode 0, MSB first) that gives the external MCU read/write
//   access to the CPLD control registers. A frame is one address byte
//   followed by zero or more data bytes. The address auto-increments after
//   each data byte. During the address byte the slave returns `status`.
//   During each data byte it returns the register at the current address.
//
// Ports
//   rst_n        async active-low reset
//   clk28        system clock
//   spi_sck      SPI clock from MCU (async to clk28)
//   spi_cs_n     SPI chip select, active-low
//   spi_mosi     SPI data in
//   spi_miso     SPI data out (MISO_IDLE outside a frame)
//   spi_miso_oe  MISO output enable, high while a frame is active
//   status       byte returned during the address byte
//   rd_addr      address whose value is returned next
//   rd_data      combinational value of register at rd_addr
//   wr_stb       one-cycle write strobe
//   wr_addr      address qualified by wr_stb
//   wr_data      data qualified by wr_stb
//   frame_err    one-cycle pulse, frame ended on a non-byte boundary
`timescale 1ns/1ps
module mcu_spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        MISO_IDLE   = 1'b1
) (
  input  logic       rst_n,
  input  logic       clk28,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] status,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic       r_sck_d, r_cs_d;
  logic       w_sck_s, w_cs_s, w_mosi_s;
  logic       w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic       w_rise_ok, w_fall_ok, w_byte_done, w_rl_set;
  logic [7:0] w_rx_byte;

  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_sh, r_tx_sh, r_rd_addr, r_wr_addr, r_wr_data;
  logic       r_miso, r_oe, r_wr_stb, r_frame_err, r_inc_pend;
  logic [1:0] r_rl;

  // cs_n synchroniser resets to 0 (not 1) so that releasing reset while the
  // MCU still holds cs_n low never looks like a falling edge; a new frame
  // needs a genuine high-to-low transition.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_d     <= w_sck_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;
  assign w_cs_fall  = ~w_cs_s & r_cs_d;

  // A CS rise forces w_cs_s high, so gating on ~w_cs_s also gives CS rise
  // priority over a coincident SCK edge.
  assign w_rise_ok   = w_sck_rise & ~w_cs_s & (r_state != ST_IDLE);
  assign w_fall_ok   = w_sck_fall & ~w_cs_s & (r_state != ST_IDLE);
  assign w_byte_done = w_rise_ok & (r_bit_cnt == 3'd7);
  assign w_rx_byte   = {r_rx_sh[6:0], w_mosi_s};
  // rd_addr changes either on address capture or on the post-write
  // increment; tx_sh reloads from rd_data two cycles after either.
  assign w_rl_set    = r_inc_pend | (w_byte_done & (r_state == ST_ADDR));

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_cs_fall) w_state_nxt = ST_ADDR;
      ST_ADDR: begin
        if (w_cs_rise)        w_state_nxt = ST_IDLE;
        else if (w_byte_done) w_state_nxt = ST_DATA;
      end
      ST_DATA: if (w_cs_rise) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_miso      <= MISO_IDLE;
      r_oe        <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_frame_err <= 1'b0;
      r_inc_pend  <= 1'b0;
      r_rl        <= '0;
    end else begin
      r_wr_stb    <= 1'b0;
      r_frame_err <= 1'b0;
      r_inc_pend  <= 1'b0;
      r_rl        <= {r_rl[0], w_rl_set};
      if (r_inc_pend) r_rd_addr <= r_rd_addr + 8'd1;
      if (r_rl[1])    r_tx_sh   <= rd_data;

      if (r_state == ST_IDLE) begin
        r_miso <= MISO_IDLE;
        r_oe   <= 1'b0;
        if (w_cs_fall) begin
          r_bit_cnt <= '0;
          r_tx_sh   <= status;
          r_miso    <= status[7];
          r_oe      <= 1'b1;
        end
      end else if (w_cs_rise) begin
        r_frame_err <= (r_bit_cnt != 3'd0);
        r_bit_cnt   <= '0;
        r_miso      <= MISO_IDLE;
        r_oe        <= 1'b0;
      end else if (w_rise_ok) begin
        r_rx_sh   <= w_rx_byte;
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (w_byte_done) begin
          if (r_state == ST_ADDR) begin
            r_rd_addr <= w_rx_byte;
          end else begin
            r_wr_stb   <= 1'b1;
            r_wr_addr  <= r_rd_addr;
            r_wr_data  <= w_rx_byte;
            r_inc_pend <= 1'b1;
          end
        end
      end else if (w_fall_ok) begin
        // bit_cnt == 0 on a fall means the 8th bit just went by: present the
        // MSB of the freshly reloaded byte instead of shifting.
        if (r_bit_cnt != 3'd0) begin
          r_tx_sh <= {r_tx_sh[6:0], 1'b0};
          r_miso  <= r_tx_sh[6];
        end else begin
          r_miso  <= r_tx_sh[7];
        end
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe;
  assign rd_addr     = r_rd_addr;
  assign wr_stb      = r_wr_stb;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Directed testbench for mcu_spi_slave. Register owner model returns
// rd_data = rd_addr ^ 8'hC3; expected values below are hand-computed.
`timescale 1ns/1ps
module tb_mcu_spi_slave;

  logic       rst_n, clk28, spi_sck, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] status, rd_addr, rd_data, wr_addr, wr_data;
  logic       wr_stb, frame_err;

  int unsigned n_checks, n_pass, err_cycles;
  logic [15:0] stb_q[$];

  mcu_spi_slave #(.SYNC_STAGES(2), .MISO_IDLE(1'b1)) u_dut (
    .rst_n(rst_n), .clk28(clk28), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .status(status), .rd_addr(rd_addr), .rd_data(rd_data), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
  );

  assign rd_data = rd_addr ^ 8'hC3;

  initial clk28 = 1'b0;
  always #18 clk28 = ~clk28;

  always @(negedge clk28) begin
    if (wr_stb)    stb_q.push_back({wr_addr, wr_data});
    if (frame_err) err_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_log();
    stb_q.delete();
    err_cycles = 0;
  endtask

  task automatic send_frame(input int nbits, input logic [31:0] mosi_v,
                            output logic [31:0] miso_v, output logic oe_all);
    clear_log();
    miso_v   = '0;
    oe_all   = 1'b1;
    spi_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_v[nbits-1-i];
      repeat (8) @(negedge clk28);
      miso_v  = {miso_v[30:0], spi_miso};
      oe_all  = oe_all & spi_miso_oe;
      spi_sck = 1'b1;
      repeat (8) @(negedge clk28);
      spi_sck = 1'b0;
    end
    repeat (8) @(negedge clk28);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk28);
  endtask

  logic [31:0] miso_v;
  logic        oe_all;

  initial begin
    n_checks = 0; n_pass = 0; err_cycles = 0;
    rst_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    status = 8'hA5;
    repeat (4) @(negedge clk28);
    check("rst_miso",  32'(spi_miso),    32'h1);
    check("rst_oe",    32'(spi_miso_oe), 32'h0);
    check("rst_stb",   32'(wr_stb),      32'h0);
    check("rst_err",   32'(frame_err),   32'h0);
    check("rst_addr",  32'({rd_addr, wr_addr, wr_data}), 32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk28);
    check("idle_miso", 32'(spi_miso), 32'h1);

    // Single write: addr 10, data 3C
    send_frame(16, 32'h103C, miso_v, oe_all);
    check("f1_miso",   miso_v,             32'h0000A5D3);
    check("f1_oe",     32'(oe_all),        32'h1);
    check("f1_nstb",   32'(stb_q.size()),  32'd1);
    if (stb_q.size() > 0) check("f1_stb0", 32'(stb_q[0]), 32'h103C);
    check("f1_rdaddr", 32'(rd_addr),       32'h11);
    check("f1_err",    32'(err_cycles),    32'd0);
    check("f1_oe_end", 32'({spi_miso_oe, spi_miso}), 32'h1);

    // Burst with address wrap
    send_frame(32, 32'hFE112233, miso_v, oe_all);
    check("f2_miso",   miso_v,             32'hA53D3CC3);
    check("f2_nstb",   32'(stb_q.size()),  32'd3);
    if (stb_q.size() == 3) begin
      check("f2_stb0", 32'(stb_q[0]), 32'hFE11);
      check("f2_stb1", 32'(stb_q[1]), 32'hFF22);
      check("f2_stb2", 32'(stb_q[2]), 32'h0033);
    end
    check("f2_rdaddr", 32'(rd_addr),       32'h01);

    // 12-bit frame: partial byte discarded, error pulse
    send_frame(12, 32'h0000020F, miso_v, oe_all);
    check("f3_err",    32'(err_cycles),    32'd1);
    check("f3_nstb",   32'(stb_q.size()),  32'd0);
    check("f3_rdaddr", 32'(rd_addr),       32'h20);

    send_frame(16, 32'h3077, miso_v, oe_all);
    check("f4_miso",   miso_v,             32'h0000A5F3);
    check("f4_nstb",   32'(stb_q.size()),  32'd1);
    if (stb_q.size() > 0) check("f4_stb0", 32'(stb_q[0]), 32'h3077);
    check("f4_err",    32'(err_cycles),    32'd0);

    // Address-only frame
    send_frame(8, 32'h40, miso_v, oe_all);
    check("f5_nstb",   32'(stb_q.size()),  32'd0);
    check("f5_err",    32'(err_cycles),    32'd0);
    check("f5_rdaddr", 32'(rd_addr),       32'h40);

    // SCK activity with CS high is ignored
    clear_log();
    for (int i = 0; i < 16; i++) begin
      spi_mosi = i[0];
      spi_sck  = 1'b1; repeat (8) @(negedge clk28);
      spi_sck  = 1'b0; repeat (8) @(negedge clk28);
    end
    check("csh_miso",  32'({spi_miso_oe, spi_miso}), 32'h1);
    check("csh_rdaddr",32'(rd_addr),       32'h40);
    check("csh_stb",   32'(stb_q.size() + err_cycles), 32'd0);

    // Reset mid-frame
    clear_log();
    spi_cs_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spi_mosi = 1'b1;
      repeat (8) @(negedge clk28); spi_sck = 1'b1;
      repeat (8) @(negedge clk28); spi_sck = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mrst_out",  32'({spi_miso_oe, spi_miso, wr_stb, frame_err}), 32'h4);
    check("mrst_addr", 32'(rd_addr),       32'h00);
    repeat (2) @(negedge clk28);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(negedge clk28); spi_sck = 1'b1;
      repeat (8) @(negedge clk28); spi_sck = 1'b0;
    end
    check("mrst_oe",   32'(spi_miso_oe),   32'h0);
    repeat (8) @(negedge clk28);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk28);
    check("mrst_quiet",32'(stb_q.size() + err_cycles), 32'd0);

    send_frame(16, 32'h559A, miso_v, oe_all);
    check("f6_miso",   miso_v,             32'h0000A596);
    check("f6_nstb",   32'(stb_q.size()),  32'd1);
    if (stb_q.size() > 0) check("f6_stb0", 32'(stb_q[0]), 32'h559A);
    check("f6_rdaddr", 32'(rd_addr),       32'h56);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mcu_spi_slave.md
Name: mcu_spi_slave

Overview:
- SPI slave (mode 0, MSB first) that lets the external MCU write and read the CPLD's control registers.
- The MCU is the SPI master. This block is the responder-side counterpart of the SD-card SPI master.
- Frame format: an address byte, then one or more data bytes. The address auto-increments after each data byte.
- Each completed data byte becomes a one-cycle write strobe in the clk28 domain. Readback data is shifted out on MISO in the same frame.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on spi_sck, spi_cs_n and spi_mosi (minimum 2).
- MISO_IDLE, 1'b1, value driven on spi_miso while no frame is active.

Ports:
- rst_n  input  1  asynchronous reset, active-low
- clk28  input  1  system clock, 28 MHz
- spi_sck  input  1  SPI clock from MCU, asynchronous to clk28
- spi_cs_n  input  1  SPI chip select from MCU, active-low
- spi_mosi  input  1  SPI data from MCU
- spi_miso  output  1  SPI data to MCU
- spi_miso_oe  output  1  MISO output enable (1 while frame active)
- status  input  8  status byte returned during the address byte
- rd_addr  output  8  register address whose value is to be returned next
- rd_data  input  8  value of register at rd_addr, combinational from owner
- wr_stb  output  1  one-clk28 write strobe
- wr_addr  output  8  address qualified by wr_stb
- wr_data  output  8  data qualified by wr_stb
- frame_err  output  1  one-clk28 pulse: frame ended on a non-byte boundary

Behaviour:
- Reset values:
  - spi_miso = MISO_IDLE, spi_miso_oe = 0.
  - rd_addr = 0, wr_stb = 0, wr_addr = 0, wr_data = 0, frame_err = 0.
  - Internal: bit_cnt = 0, phase = IDLE, rx/tx shift registers = 0.
- Synchronisation: spi_sck, spi_cs_n and spi_mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronised signals by comparing with a one-cycle-delayed copy.
- Timing constraints on the MCU:
  - SCK high and low times ≥ 6 clk28 cycles (SCK ≤ 2.33 MHz).
  - CS-low to first SCK rise ≥ 6 clk28 cycles.
  - Last SCK fall to CS high ≥ 4 clk28 cycles.
- States: IDLE, ADDR, DATA.
- IDLE:
  - spi_miso_oe = 0, spi_miso = MISO_IDLE.
  - On synced cs_n falling edge → ADDR, bit_cnt = 0, tx_sh = status, spi_miso = status[7], oe = 1.
- SCK rising edge (cs_n low, state ≠ IDLE):
  - rx_sh = {rx_sh[6:0], mosi}; bit_cnt++ (3-bit, wraps 7→0).
  - When bit_cnt was 7, the byte is complete:
    - ADDR: rd_addr = byte; state → DATA; a reload of tx_sh from rd_data is scheduled exactly 2 clk28 later.
    - DATA: wr_stb = 1 for one cycle, with wr_addr = rd_addr and wr_data = byte. The next cycle rd_addr = rd_addr + 1 (8-bit, FF wraps to 00). tx_sh reloads from rd_data 2 clk28 after the increment.
- SCK falling edge (cs_n low, state ≠ IDLE):
  - After a bit that was not a byte's 8th: tx_sh shifts left and spi_miso = tx_sh[6] (next bit).
  - After a byte's 8th bit: spi_miso = tx_sh[7] of the reloaded value. The reload always precedes this falling edge by the SCK timing constraint.
- Readback semantics: data byte n on MISO returns the register at (start address + n) before any write in the same byte slot. Read and write of the same address overlap; the read happens first.
- Synced cs_n rising edge (any state ≠ IDLE) → IDLE:
  - If bit_cnt ≠ 0: frame_err pulses 1 cycle and the partial byte is discarded (no wr_stb).
  - A frame holding only the address byte is legal: no strobe, no error.
- cs_n rising on the same cycle as a SCK rising edge: the edge is ignored and the CS rising edge takes priority.
- SCK edges while cs_n is high are ignored.
- Reset mid-frame: returns to IDLE immediately with no strobes. The next frame requires a fresh cs_n falling edge.

Test Plan:
- Reset, then idle: spi_miso = 1, oe = 0, all strobes 0. Pulse rst_n low mid-frame → same values within 1 cycle.
- status = 8'hA5; send frame {8'h10, 8'h3C}:
  - MISO returns A5 then rd_data(0x10).
  - Exactly one wr_stb with wr_addr = 0x10, wr_data = 0x3C.
  - rd_addr ends at 0x11.
- Burst {8'hFE, 11, 22, 33}: wr_stb at FE/11, FF/22, 00/33; rd_addr wraps to 0x01.
- Frame of 12 bits {8'h20, 4'hF}: frame_err is one pulse; no wr_stb; next full frame works normally.
- Address-only frame {8'h40}: no wr_stb, no frame_err, rd_addr = 0x40.
- SCK toggled 16× with cs_n high: no state change, MISO = MISO_IDLE.
